// File: rtl/jk_reg_bank.sv
// WIDTH-channel JK/D/T register bank that updates on a divided tick strobe.
// Also provides a blink output, a change strobe and a saturating change counter.
module jk_reg_bank #(
    parameter int               WIDTH   = 4,
    parameter int               DIV     = 20000000,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             blink,
    output logic             changed,
    output logic [7:0]       chg_count
);

    localparam logic [26:0] LAST = 27'(DIV - 1);

    logic [26:0]      count;
    logic             wrap;
    logic [WIDTH-1:0] nxt;

    assign wrap = (count == LAST);

    // JK rule per bit: set on j, keep unless k, so 11 toggles
    always_comb begin
        nxt = q;
        unique case (mode)
            2'b00:   nxt = (j & ~q) | (~k & q);
            2'b01:   nxt = j;
            2'b10:   nxt = q ^ j;
            default: nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            tick      <= 1'b0;
            blink     <= 1'b0;
            changed   <= 1'b0;
            chg_count <= '0;
            q         <= RST_VAL;
        end else begin
            count   <= wrap ? '0 : count + 27'd1;
            tick    <= wrap;
            changed <= 1'b0;
            if (wrap)
                blink <= ~blink;
            // A load on the tick edge discards that tick's update
            if (load) begin
                q <= load_val;
            end else if (wrap) begin
                q <= nxt;
                if (nxt != q) begin
                    changed <= 1'b1;
                    if (chg_count != 8'd255)
                        chg_count <= chg_count + 8'd1;
                end
            end
        end
    end

endmodule
